// File: rtl/count_pkg.sv
// count_pkg
//   Shared types and helpers for the counter blocks.
//   cnt_state_t  : down-counter control states (IDLE / RUN / DONE)
//   presc_width(): bit width needed for a 0..p-1 prescaler (never below 1)
package count_pkg;

  typedef enum logic [1:0] {
    CNT_IDLE = 2'd0,
    CNT_RUN  = 2'd1,
    CNT_DONE = 2'd2
  } cnt_state_t;

  // A prescaler of 1 or 2 still needs one storage bit.
  function automatic int presc_width(input int p);
    if (p <= 2) return 1;
    else        return $clog2(p);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Divides the clock into one-cycle ticks while enabled. The internal count
//   runs 0..PRESCALE-1 and tick is high when it sits at PRESCALE-1, so the
//   first tick after a clear arrives PRESCALE enabled cycles later.
// Ports
//   clk    in  1  rising-edge clock
//   reset  in  1  asynchronous, active-low
//   en     in  1  count enable
//   clr    in  1  synchronous clear, wins over en and masks tick
//   tick   out 1  one-cycle tick (combinational from the count)
module tick_prescaler
  import count_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  // Masked by clr so a load never doubles as a decrement.
  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl
//   N-bit down-counter with load, start/stop control, optional auto-reload and
//   a one-cycle terminal-count pulse. Decrements happen on prescaler ticks
//   while in RUN; an expiry (tick with counter at 0) either reloads from the
//   reload register and keeps running, or parks at 0 in DONE.
// Ports
//   clk          in  1  rising-edge clock
//   reset        in  1  asynchronous, active-low
//   start        in  1  begin/resume counting (level, sampled each edge)
//   stop         in  1  halt counting and hold value (wins over start)
//   load         in  1  write load_val into counter and reload register
//   load_val     in  N  value for load
//   auto_reload  in  1  1: reload on expiry and keep running; 0: go to DONE
//   counter      out N  current count
//   busy         out 1  high while in RUN
//   tc           out 1  one-cycle pulse per expiry
//   done         out 1  high while in DONE
module down_counter_ctrl
  import count_pkg::*;
#(
  parameter int N        = 4,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         auto_reload,
  output logic [N-1:0] counter,
  output logic         busy,
  output logic         tc,
  output logic         done
);

  cnt_state_t   state;
  logic [N-1:0] reload_reg;
  logic         tick;
  logic         presc_en;
  logic         presc_clr;

  // The prescaler only runs in RUN; holding it clear elsewhere guarantees it
  // starts from 0 on every entry to RUN.
  assign presc_en  = (state == CNT_RUN);
  assign presc_clr = load || (state != CNT_RUN);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CNT_IDLE;
      counter    <= '1;
      reload_reg <= '1;
      busy       <= 1'b0;
      tc         <= 1'b0;
      done       <= 1'b0;
    end else begin
      tc <= 1'b0;

      // Load applies in every state; tick is already masked on a load edge,
      // so the decrement/reload paths below never compete with it.
      if (load) begin
        counter    <= load_val;
        reload_reg <= load_val;
      end

      unique case (state)
        CNT_IDLE: begin
          if (!stop && start) begin
            state <= CNT_RUN;
            busy  <= 1'b1;
          end
        end

        CNT_RUN: begin
          // Expiry still pulses tc even when stop takes the same edge.
          if (tick && (counter == '0)) begin
            tc <= 1'b1;
          end
          if (stop) begin
            state <= CNT_IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            if (counter != '0) begin
              counter <= counter - N'(1);
            end else if (auto_reload) begin
              counter <= reload_reg;
            end else begin
              state <= CNT_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        CNT_DONE: begin
          if (stop) begin
            state <= CNT_IDLE;
            done  <= 1'b0;
          end else if (start) begin
            state <= CNT_RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
            if (!load) begin
              counter <= reload_reg;
            end
          end
        end

        default: begin
          state <= CNT_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter_ctrl.sv
module tb_down_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       auto_reload = 1'b0;

  logic [3:0] counter_a, counter_b;
  logic       busy_a, tc_a, done_a;
  logic       busy_b, tc_b, done_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  down_counter_ctrl #(.N(4), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .auto_reload(auto_reload),
    .counter(counter_a), .busy(busy_a), .tc(tc_a), .done(done_a)
  );

  down_counter_ctrl #(.N(4), .PRESCALE(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .auto_reload(auto_reload),
    .counter(counter_b), .busy(busy_b), .tc(tc_b), .done(done_b)
  );

  typedef struct {
    logic       ld;
    logic [3:0] lv;
    logic       st;
    logic       sp;
    logic       ar;
    logic [3:0] e_cnt;
    logic       e_busy;
    logic       e_tc;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_a(input string tag, input logic [3:0] c, input logic b,
                         input logic t, input logic d);
    chk({tag, ".counter"}, 32'(counter_a), 32'(c));
    chk({tag, ".busy"},    32'(busy_a),    32'(b));
    chk({tag, ".tc"},      32'(tc_a),      32'(t));
    chk({tag, ".done"},    32'(done_a),    32'(d));
  endtask

  // Drive inputs just after an edge, let the next edge sample them, then
  // look at the outputs 1 time unit later.
  task automatic step(input logic ld, input logic [3:0] lv, input logic st,
                      input logic sp, input logic ar);
    load = ld; load_val = lv; start = st; stop = sp; auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(input logic ld, input logic [3:0] lv, input logic st,
                             input logic sp, input logic ar, input logic [3:0] c,
                             input logic b, input logic t, input logic d);
    vec_t r;
    r.ld = ld; r.lv = lv; r.st = st; r.sp = sp; r.ar = ar;
    r.e_cnt = c; r.e_busy = b; r.e_tc = t; r.e_done = d;
    return r;
  endfunction

  initial begin
    //           ld lv    st sp ar   cnt   busy tc done
    // load 3 + start, one-shot
    vecs.push_back(v(1, 4'd3, 1, 0, 0, 4'd3, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd2, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd1, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 1));
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1));
    // from DONE: load 2 + start, auto-reload
    vecs.push_back(v(1, 4'd2, 1, 0, 1, 4'd2, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 1, 4'd1, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 1, 4'd0, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 1, 4'd2, 1, 1, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 1, 4'd1, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 1, 4'd0, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 1, 4'd2, 1, 1, 0));
    // load 7 while running, stop at 5, resume
    vecs.push_back(v(1, 4'd7, 0, 0, 1, 4'd7, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 1, 4'd6, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 1, 4'd5, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 1, 1, 4'd5, 0, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 1, 4'd5, 0, 0, 0));
    vecs.push_back(v(0, 4'd0, 1, 0, 1, 4'd5, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 1, 4'd4, 1, 0, 0));
    // run down with auto_reload=0, stop on the expiry edge
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd3, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd2, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd1, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 1, 0, 4'd0, 0, 1, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0));
    // load+start+stop in IDLE: loads, stays IDLE
    vecs.push_back(v(1, 4'd9, 1, 1, 0, 4'd9, 0, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd9, 0, 0, 0));
    // DONE then start: reloads from reload register
    vecs.push_back(v(1, 4'd1, 1, 0, 0, 4'd1, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 1));
    vecs.push_back(v(0, 4'd0, 1, 0, 0, 4'd1, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 0));
    vecs.push_back(v(0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 1));
    vecs.push_back(v(0, 4'd0, 0, 1, 0, 4'd0, 0, 0, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_a("reset", 4'hF, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].ar);
      check_a($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_busy,
              vecs[i].e_tc, vecs[i].e_done);
    end

    // Asynchronous reset in the middle of RUN takes effect before the next edge
    step(1, 4'd8, 1, 0, 0);
    step(0, 4'd0, 0, 0, 0);
    step(0, 4'd0, 0, 0, 0);
    check_a("pre_rst", 4'd6, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_a("async_rst", 4'hF, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_a("rst_hold", 4'hF, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // PRESCALE=3: load 2 + start, decrement every third edge, tc on edge 9
    step(1, 4'd2, 1, 0, 0);
    chk("p3.start.counter", 32'(counter_b), 32'd2);
    chk("p3.start.busy", 32'(busy_b), 32'd1);
    for (int j = 1; j <= 10; j++) begin
      logic [3:0] e_c;
      step(0, 4'd0, 0, 0, 0);
      e_c = (j < 9) ? 4'(2 - j / 3) : 4'd0;
      chk($sformatf("p3.e%0d.counter", j), 32'(counter_b), 32'(e_c));
      chk($sformatf("p3.e%0d.tc", j), 32'(tc_b), 32'(j == 9));
      chk($sformatf("p3.e%0d.done", j), 32'(done_b), 32'(j >= 9));
      chk($sformatf("p3.e%0d.busy", j), 32'(busy_b), 32'(j < 9));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
